// File: rtl/seq_monitor.sv
// Sequence-generator monitor: locks onto an 8-state code cycle, then tracks it,
// counting mismatches and wraps, and latching a sticky fault after repeated errors.
module seq_monitor #(
  parameter int LOCK_N  = 3,
  parameter int FAULT_N = 2
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       en,
  input  logic [2:0] x,
  input  logic       clr,
  output logic       locked,
  output logic       fault,
  output logic       wrap,
  output logic [7:0] wrap_cnt,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_TRACK = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] prev_x_reg, prev_x_next;
  logic [3:0] good_cnt_reg, good_cnt_next;
  logic [3:0] bad_cnt_reg, bad_cnt_next;
  logic       wrap_reg, wrap_next;
  logic [7:0] wrap_cnt_reg, wrap_cnt_next;
  logic [7:0] err_cnt_reg, err_cnt_next;
  logic       locked_reg, locked_next;
  logic       fault_reg, fault_next;
  logic       match;

  // Expected successor of code p in the legal cycle.
  function automatic logic [2:0] predict(input logic [2:0] p);
    predict = {(p[1] ^ p[0]) ^ ~(p[2] | p[1]), p[2], p[1]};
  endfunction

  assign match = (x == predict(prev_x_reg));

  always_comb begin
    state_next    = state_reg;
    prev_x_next   = prev_x_reg;
    good_cnt_next = good_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    wrap_next     = 1'b0;
    wrap_cnt_next = wrap_cnt_reg;
    err_cnt_next  = err_cnt_reg;

    if (clr) begin
      // clr wins over a simultaneous sample, which is dropped entirely
      state_next    = S_IDLE;
      good_cnt_next = 4'd0;
      bad_cnt_next  = 4'd0;
      wrap_cnt_next = 8'd0;
      err_cnt_next  = 8'd0;
    end else if (en) begin
      prev_x_next = x;
      case (state_reg)
        S_IDLE: begin
          good_cnt_next = 4'd0;
          state_next    = S_ACQ;
        end
        S_ACQ: begin
          if (match) begin
            if (good_cnt_reg + 4'd1 == 4'(LOCK_N)) begin
              state_next    = S_TRACK;
              good_cnt_next = 4'd0;
              bad_cnt_next  = 4'd0;
            end else begin
              good_cnt_next = good_cnt_reg + 4'd1;
            end
          end else begin
            good_cnt_next = 4'd0;
          end
        end
        S_TRACK: begin
          if (match) begin
            bad_cnt_next = 4'd0;
            if (x == 3'b000) begin
              wrap_next     = 1'b1;
              wrap_cnt_next = wrap_cnt_reg + 8'd1;
            end
          end else begin
            if (err_cnt_reg != 8'hFF) err_cnt_next = err_cnt_reg + 8'd1;
            if (bad_cnt_reg + 4'd1 == 4'(FAULT_N)) begin
              state_next   = S_FAULT;
              bad_cnt_next = 4'd0;
            end else begin
              bad_cnt_next = bad_cnt_reg + 4'd1;
            end
          end
        end
        default: begin
          state_next = S_FAULT;
        end
      endcase
    end

    locked_next = (state_next == S_TRACK);
    fault_next  = (state_next == S_FAULT);
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_reg    <= S_IDLE;
      prev_x_reg   <= 3'b000;
      good_cnt_reg <= 4'd0;
      bad_cnt_reg  <= 4'd0;
      wrap_reg     <= 1'b0;
      wrap_cnt_reg <= 8'd0;
      err_cnt_reg  <= 8'd0;
      locked_reg   <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      prev_x_reg   <= prev_x_next;
      good_cnt_reg <= good_cnt_next;
      bad_cnt_reg  <= bad_cnt_next;
      wrap_reg     <= wrap_next;
      wrap_cnt_reg <= wrap_cnt_next;
      err_cnt_reg  <= err_cnt_next;
      locked_reg   <= locked_next;
      fault_reg    <= fault_next;
    end
  end

  assign locked   = locked_reg;
  assign fault    = fault_reg;
  assign wrap     = wrap_reg;
  assign wrap_cnt = wrap_cnt_reg;
  assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_seq_monitor.sv
// Bench for seq_monitor: directed vector table, gap/clr/async-reset sequences,
// then randomized traffic against a cycle-list reference model.
module tb_seq_monitor;

  localparam int LOCK_N  = 3;
  localparam int FAULT_N = 2;

  logic       clk = 1'b0;
  logic       aclr = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] x = 3'b000;
  logic       locked, fault, wrap;
  logic [7:0] wrap_cnt, err_cnt;

  int vectors = 0;
  int miscompares = 0;

  seq_monitor #(.LOCK_N(LOCK_N), .FAULT_N(FAULT_N)) dut (
    .clk(clk), .aclr(aclr), .en(en), .x(x), .clr(clr),
    .locked(locked), .fault(fault), .wrap(wrap),
    .wrap_cnt(wrap_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the legal cycle as an ordered list, state as plain integers.
  logic [2:0] cycle_list [8] = '{3'b000, 3'b100, 3'b010, 3'b101,
                                  3'b110, 3'b111, 3'b011, 3'b001};
  int         m_mode;  // 0 idle, 1 acquiring, 2 tracking, 3 faulted
  logic [2:0] m_prev;
  int         m_good, m_bad, m_wc, m_ec;
  bit         m_wrap;

  function automatic logic [2:0] successor(input logic [2:0] p);
    successor = 3'b000;
    for (int i = 0; i < 8; i++)
      if (cycle_list[i] == p) successor = cycle_list[(i + 1) % 8];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 3'b000; m_good = 0; m_bad = 0;
    m_wc = 0; m_ec = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit s_en, input bit s_clr, input logic [2:0] s_x);
    bit is_match;
    m_wrap = 0;
    if (s_clr) begin
      m_mode = 0; m_good = 0; m_bad = 0; m_wc = 0; m_ec = 0;
    end else if (s_en) begin
      is_match = (s_x == successor(m_prev));
      case (m_mode)
        0: begin m_good = 0; m_mode = 1; end
        1: if (is_match) begin
             m_good++;
             if (m_good == LOCK_N) begin m_mode = 2; m_bad = 0; end
           end else m_good = 0;
        2: if (is_match) begin
             m_bad = 0;
             if (s_x == 3'b000) begin m_wrap = 1; m_wc = (m_wc + 1) % 256; end
           end else begin
             if (m_ec < 255) m_ec++;
             m_bad++;
             if (m_bad == FAULT_N) m_mode = 3;
           end
        default: ;
      endcase
      m_prev = s_x;
    end
  endtask

  task automatic compare(input string tag, input bit e_l, input bit e_f, input bit e_w,
                         input logic [7:0] e_wc, input logic [7:0] e_ec);
    vectors++;
    if (locked !== e_l || fault !== e_f || wrap !== e_w || wrap_cnt !== e_wc || err_cnt !== e_ec) begin
      miscompares++;
      $display("FAIL %s: got l=%b f=%b w=%b wc=%0d ec=%0d, want l=%b f=%b w=%b wc=%0d ec=%0d",
               tag, locked, fault, wrap, wrap_cnt, err_cnt, e_l, e_f, e_w, e_wc, e_ec);
    end else begin
      $display("vec %0d %s ok: l=%b f=%b w=%b wc=%0d ec=%0d",
               vectors, tag, locked, fault, wrap, wrap_cnt, err_cnt);
    end
  endtask

  task automatic compare_model(input string tag);
    compare(tag, m_mode == 2, m_mode == 3, m_wrap, 8'(m_wc), 8'(m_ec));
  endtask

  // Drive one cycle of inputs away from the active edge, then sample after it.
  task automatic step(input bit s_en, input bit s_clr, input logic [2:0] s_x);
    @(negedge clk);
    en = s_en; clr = s_clr; x = s_x;
    model_step(s_en, s_clr, s_x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    aclr = 1'b0; en = 1'b0; clr = 1'b0;
    model_reset();
    @(negedge clk);
    aclr = 1'b1;
  endtask

  typedef struct {
    bit         en;
    bit         clr;
    logic [2:0] x;
    bit         l;
    bit         f;
    bit         w;
    logic [7:0] wc;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl [33];

  initial begin
    tbl[0]  = '{1, 0, 3'b000, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 3'b100, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 3'b010, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 3'b101, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 3'b110, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 3'b111, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 3'b011, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 3'b001, 1, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 3'b000, 1, 0, 1, 1, 0};
    tbl[9]  = '{1, 0, 3'b100, 1, 0, 0, 1, 0};
    tbl[10] = '{1, 0, 3'b010, 1, 0, 0, 1, 0};
    tbl[11] = '{1, 0, 3'b101, 1, 0, 0, 1, 0};
    tbl[12] = '{1, 0, 3'b110, 1, 0, 0, 1, 0};
    tbl[13] = '{1, 0, 3'b111, 1, 0, 0, 1, 0};
    tbl[14] = '{1, 0, 3'b011, 1, 0, 0, 1, 0};
    tbl[15] = '{1, 0, 3'b001, 1, 0, 0, 1, 0};
    tbl[16] = '{1, 0, 3'b000, 1, 0, 1, 2, 0};
    tbl[17] = '{0, 0, 3'b000, 1, 0, 0, 2, 0};
    tbl[18] = '{1, 0, 3'b100, 1, 0, 0, 2, 0};
    tbl[19] = '{1, 0, 3'b010, 1, 0, 0, 2, 0};
    tbl[20] = '{1, 0, 3'b111, 1, 0, 0, 2, 1};
    tbl[21] = '{1, 0, 3'b011, 1, 0, 0, 2, 1};
    tbl[22] = '{1, 0, 3'b001, 1, 0, 0, 2, 1};
    tbl[23] = '{1, 0, 3'b000, 1, 0, 1, 3, 1};
    tbl[24] = '{1, 0, 3'b100, 1, 0, 0, 3, 1};
    tbl[25] = '{1, 0, 3'b000, 1, 0, 0, 3, 2};
    tbl[26] = '{1, 0, 3'b110, 0, 1, 0, 3, 3};
    tbl[27] = '{1, 0, 3'b100, 0, 1, 0, 3, 3};
    tbl[28] = '{1, 1, 3'b000, 0, 0, 0, 0, 0};
    tbl[29] = '{1, 0, 3'b100, 0, 0, 0, 0, 0};
    tbl[30] = '{1, 0, 3'b010, 0, 0, 0, 0, 0};
    tbl[31] = '{1, 0, 3'b101, 0, 0, 0, 0, 0};
    tbl[32] = '{1, 0, 3'b110, 1, 0, 0, 0, 0};

    model_reset();
    #1;
    compare("reset_async", 0, 0, 0, 8'd0, 8'd0);
    do_reset();

    for (int i = 0; i < 33; i++) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].x);
      compare($sformatf("tbl%0d", i), tbl[i].l, tbl[i].f, tbl[i].w, tbl[i].wc, tbl[i].ec);
    end

    // Gapped acquisition: lock timing counts samples, not cycles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, cycle_list[i]);
      compare($sformatf("gap_s%0d", i), i == 3, 0, 0, 8'd0, 8'd0);
      for (int g = 0; g < 5; g++) step(0, 0, 3'($urandom_range(0, 7)));
    end
    compare("gap_hold", 1, 0, 0, 8'd0, 8'd0);
    for (int i = 4; i < 9; i++) step(1, 0, cycle_list[i % 8]);
    compare("gap_wrap", 1, 0, 1, 8'd1, 8'd0);
    step(1, 0, 3'b111);
    compare("gap_err", 1, 0, 0, 8'd1, 8'd1);

    // Reset asserted between edges must clear outputs before the next edge.
    #2;
    aclr = 1'b0;
    model_reset();
    #1;
    compare("async_mid", 0, 0, 0, 8'd0, 8'd0);
    @(negedge clk);
    aclr = 1'b1;
    step(1, 0, 3'b011);
    compare("post_rst", 0, 0, 0, 8'd0, 8'd0);

    // Randomized traffic, mostly legal successors with injected errors and clears.
    for (int i = 0; i < 400; i++) begin
      bit r_en, r_clr;
      logic [2:0] r_x;
      r_en  = ($urandom_range(0, 3) != 0);
      r_clr = ($urandom_range(0, 59) == 0);
      r_x   = ($urandom_range(0, 9) < 8) ? successor(m_prev) : 3'($urandom_range(0, 7));
      step(r_en, r_clr, r_x);
      compare_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
